parking_controller_nslot: RTL and testbench
===========================================

PARKING_CONTROLLER_NSLOT -- requirements
Module: parking_controller_nslot

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8, number of slots (2..32); SW = $clog2(NUM_SLOTS).
REQ-002 SHALL have parameter TICKS_PER_UNIT, default 100, clk cycles per billing time unit.
REQ-003 SHALL have parameter RATE, default 5, fee per billed unit.
REQ-004 SHALL have parameter GRACE_UNITS, default 2, free units before billing starts.
REQ-005 SHALL have parameter GATE_CYCLES, default 4, cycles each gate stays open.
REQ-006 SHALL have parameter PAY_TIMEOUT, default 1000, cycles allowed for payment.
REQ-007 clk  input  1  single system clock, rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 entry_req  input  1  single-cycle pulse: car at entry.
REQ-010 exit_req  input  1  single-cycle pulse: car at exit; slot given by exit_slot_sel.
REQ-011 exit_slot_sel  input  SW  slot of the exiting car, sampled with exit_req.
REQ-012 payment_received  input  1  pulse: fee paid.
REQ-013 entry_gate / exit_gate  output  1 each  gate open.
REQ-014 full  output  1  high when no slot is free.
REQ-015 occupancy  output  NUM_SLOTS  bit i = slot i occupied.
REQ-016 free_count  output  SW+1  number of free slots.
REQ-017 alloc_valid / alloc_slot  output  1 / SW  one-cycle pulse plus the granted slot.
REQ-018 fee_ready / fee  output  1 / 32  fee valid (level) and fee value.
REQ-019 deny / exit_err / pay_timeout  output  1 each  one-cycle status pulses.

Function
REQ-020 FSM states SHALL be IDLE, ENTRY_OPEN, BILL, AWAIT_PAY, EXIT_OPEN.
REQ-021 Requests SHALL be accepted only in IDLE; pulses arriving in other states are dropped.
- Simultaneous entry_req and exit_req in IDLE: exit serviced; entry dropped.
REQ-022 Entry in IDLE with a free slot: next cycle alloc_valid=1, alloc_slot = lowest-index free slot, that occupancy bit set, its timer cleared, go to ENTRY_OPEN.
REQ-023 Entry in IDLE with full=1: deny pulses for 1 cycle; state stays IDLE.
REQ-024 ENTRY_OPEN: entry_gate=1 for exactly GATE_CYCLES cycles, then IDLE.
REQ-025 Exit in IDLE on an unoccupied slot: exit_err pulses for 1 cycle; state stays IDLE.
REQ-026 Exit on an occupied slot: latch the slot, go to BILL.
- BILL (1 cycle): fee = 0 if elapsed <= GRACE_UNITS, else (elapsed - GRACE_UNITS) * RATE, saturated to 2^32-1.
- Then AWAIT_PAY with fee_ready=1.
REQ-027 AWAIT_PAY, payment_received: clear occupancy bit, fee_ready=0, go to EXIT_OPEN (exit_gate=1 for GATE_CYCLES cycles), then IDLE.
REQ-028 AWAIT_PAY, PAY_TIMEOUT cycles without payment: pay_timeout pulses, fee_ready=0, slot stays occupied, go to IDLE.
REQ-029 Shared prescaler SHALL pulse every TICKS_PER_UNIT cycles; each occupied slot's 16-bit elapsed counter increments per pulse and saturates at 65535. Counters are not frozen while billing.
REQ-030 fee SHALL hold its last value until the next BILL.
REQ-031 full, free_count and occupancy SHALL be registered and consistent in the same cycle.

Reset
REQ-032 rst_n low SHALL asynchronously force:
- State IDLE; occupancy, timers, prescaler, fee, free_count MSB-form zeroed except free_count=NUM_SLOTS.
- All gates and pulses 0; full=0.
REQ-033 Reset mid-transaction SHALL abandon it and free all slots.

Structure
REQ-034 Package parking_pkg SHALL hold the FSM state enum and the 32-bit fee / 16-bit timer width constants.
REQ-035 Per-slot timer SHALL be sub-module slot_timer, instantiated NUM_SLOTS times via generate.

Verification
REQ-036 Reset, 8 entry pulses, then a 9th -> alloc_slot 0..7 in order, full=1, free_count=0, 9th gives deny, no alloc_valid.
REQ-037 Park slot 3 for 7 units, exit, pay -> fee=25 (7-2)*5, exit_gate high 4 cycles, occupancy[3]=0.
REQ-038 Exit after 1 unit -> fee=0; exit_req on an empty slot -> exit_err only.
REQ-039 Simultaneous entry_req+exit_req in IDLE -> exit serviced, no allocation; no payment for 1000 cycles -> pay_timeout, slot still occupied.
REQ-040 rst_n low during AWAIT_PAY -> all outputs at reset values immediately; free_count=8.

Source files
------------

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types, widths and fee arithmetic for the parking controller
package parking_pkg;

    localparam int FEE_W   = 32;
    localparam int TIMER_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY_OPEN,
        BILL,
        AWAIT_PAY,
        EXIT_OPEN
    } state_t;

    // Billed units beyond the grace period times the rate, clamped to the fee width.
    function automatic logic [FEE_W-1:0] calc_fee(
        input logic [TIMER_W-1:0] elapsed,
        input int unsigned        grace,
        input int unsigned        rate
    );
        logic [63:0] billed;
        if (32'(elapsed) <= grace) return '0;
        billed = 64'(32'(elapsed) - grace) * 64'(rate);
        if (billed > 64'hFFFF_FFFF) return '1;
        return billed[FEE_W-1:0];
    endfunction

endpackage

// File: rtl/slot_timer.sv
// rtl/slot_timer.sv - per-slot saturating elapsed-unit counter
module slot_timer
    import parking_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               tick,
    input  logic               active,
    output logic [TIMER_W-1:0] elapsed
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elapsed <= '0;
        end else if (clear) begin
            elapsed <= '0;
        end else if (tick && active && (elapsed != '1)) begin
            elapsed <= elapsed + 1'b1;
        end
    end

endmodule

// File: rtl/parking_controller_nslot.sv
// rtl/parking_controller_nslot.sv - N-slot parking controller with gates, billing and payment timeout
module parking_controller_nslot
    import parking_pkg::*;
#(
    parameter  int NUM_SLOTS      = 8,
    parameter  int TICKS_PER_UNIT = 100,
    parameter  int RATE           = 5,
    parameter  int GRACE_UNITS    = 2,
    parameter  int GATE_CYCLES    = 4,
    parameter  int PAY_TIMEOUT    = 1000,
    localparam int SW             = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SW-1:0]        exit_slot_sel,
    input  logic                 payment_received,
    output logic                 entry_gate,
    output logic                 exit_gate,
    output logic                 full,
    output logic [NUM_SLOTS-1:0] occupancy,
    output logic [SW:0]          free_count,
    output logic                 alloc_valid,
    output logic [SW-1:0]        alloc_slot,
    output logic                 fee_ready,
    output logic [FEE_W-1:0]     fee,
    output logic                 deny,
    output logic                 exit_err,
    output logic                 pay_timeout
);

    state_t               state;
    logic [31:0]          prescale;
    logic [31:0]          cnt;
    logic [SW-1:0]        exit_slot;
    logic [SW-1:0]        free_idx;
    logic                 tick;
    logic                 alloc_go;
    logic                 exit_ok;
    logic [NUM_SLOTS-1:0] timer_clr;
    logic [TIMER_W-1:0]   elapsed [NUM_SLOTS];

    assign tick     = (prescale == 32'(TICKS_PER_UNIT - 1));
    assign alloc_go = (state == IDLE) && entry_req && !exit_req && !full;
    assign exit_ok  = ({1'b0, exit_slot_sel} < (SW+1)'(NUM_SLOTS)) && occupancy[exit_slot_sel];

    always_comb begin
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occupancy[i]) free_idx = SW'(i);
        end
    end

    // A freshly granted slot restarts its timer on the same edge its occupancy bit sets.
    always_comb begin
        timer_clr = '0;
        if (alloc_go) timer_clr[free_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        slot_timer u_timer (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (timer_clr[i]),
            .tick    (tick),
            .active  (occupancy[i]),
            .elapsed (elapsed[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            occupancy   <= '0;
            free_count  <= (SW+1)'(NUM_SLOTS);
            full        <= 1'b0;
            cnt         <= '0;
            exit_slot   <= '0;
            fee         <= '0;
            fee_ready   <= 1'b0;
            entry_gate  <= 1'b0;
            exit_gate   <= 1'b0;
            alloc_valid <= 1'b0;
            alloc_slot  <= '0;
            deny        <= 1'b0;
            exit_err    <= 1'b0;
            pay_timeout <= 1'b0;
        end else begin
            alloc_valid <= 1'b0;
            deny        <= 1'b0;
            exit_err    <= 1'b0;
            pay_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (exit_req) begin
                        if (exit_ok) begin
                            exit_slot <= exit_slot_sel;
                            state     <= BILL;
                        end else begin
                            exit_err <= 1'b1;
                        end
                    end else if (entry_req) begin
                        if (full) begin
                            deny <= 1'b1;
                        end else begin
                            alloc_valid         <= 1'b1;
                            alloc_slot          <= free_idx;
                            occupancy[free_idx] <= 1'b1;
                            free_count          <= free_count - 1'b1;
                            full                <= (free_count == (SW+1)'(1));
                            entry_gate          <= 1'b1;
                            cnt                 <= 32'(GATE_CYCLES - 1);
                            state               <= ENTRY_OPEN;
                        end
                    end
                end
                ENTRY_OPEN: begin
                    if (cnt == '0) begin
                        entry_gate <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                BILL: begin
                    fee       <= calc_fee(elapsed[exit_slot], GRACE_UNITS, RATE);
                    fee_ready <= 1'b1;
                    cnt       <= '0;
                    state     <= AWAIT_PAY;
                end
                AWAIT_PAY: begin
                    if (payment_received) begin
                        occupancy[exit_slot] <= 1'b0;
                        free_count           <= free_count + 1'b1;
                        full                 <= 1'b0;
                        fee_ready            <= 1'b0;
                        exit_gate            <= 1'b1;
                        cnt                  <= 32'(GATE_CYCLES - 1);
                        state                <= EXIT_OPEN;
                    end else if (cnt == 32'(PAY_TIMEOUT - 1)) begin
                        pay_timeout <= 1'b1;
                        fee_ready   <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EXIT_OPEN: begin
                    if (cnt == '0) begin
                        exit_gate <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parking_controller_nslot.sv
// tb/tb_parking_controller_nslot.sv - randomized self-checking bench for parking_controller_nslot
module tb_parking_controller_nslot;

    localparam int N     = 8;
    localparam int SW    = 3;
    localparam int T     = 100;
    localparam int RATE  = 5;
    localparam int GRACE = 2;
    localparam int GATE  = 4;
    localparam int PT    = 1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          entry_req = 1'b0;
    logic          exit_req = 1'b0;
    logic          payment_received = 1'b0;
    logic [SW-1:0] exit_slot_sel = '0;
    logic          entry_gate, exit_gate, full, alloc_valid, fee_ready;
    logic          deny, exit_err, pay_timeout;
    logic [N-1:0]  occupancy;
    logic [SW:0]   free_count;
    logic [SW-1:0] alloc_slot;
    logic [31:0]   fee;

    int errors = 0;
    int checks = 0;
    int edge_cnt;
    bit m_occ   [N];
    int m_alloc [N];

    parking_controller_nslot #(
        .NUM_SLOTS(N), .TICKS_PER_UNIT(T), .RATE(RATE),
        .GRACE_UNITS(GRACE), .GATE_CYCLES(GATE), .PAY_TIMEOUT(PT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
        .exit_slot_sel(exit_slot_sel), .payment_received(payment_received),
        .entry_gate(entry_gate), .exit_gate(exit_gate), .full(full),
        .occupancy(occupancy), .free_count(free_count), .alloc_valid(alloc_valid),
        .alloc_slot(alloc_slot), .fee_ready(fee_ready), .fee(fee), .deny(deny),
        .exit_err(exit_err), .pay_timeout(pay_timeout)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; a billing unit completes on every T-th edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    // Whole units completed strictly after the allocation edge and before the billing edge.
    function automatic int units(input int a, input int b);
        int u;
        u = (b - 1) / T - a / T;
        return (u > 65535) ? 65535 : u;
    endfunction

    function automatic logic [31:0] exp_fee(input int a, input int b);
        int u;
        u = units(a, b);
        return (u <= GRACE) ? 32'd0 : 32'((u - GRACE) * RATE);
    endfunction

    function automatic int m_lowest();
        for (int i = 0; i < N; i++) if (!m_occ[i]) return i;
        return -1;
    endfunction

    function automatic int m_free();
        int c;
        c = 0;
        for (int i = 0; i < N; i++) if (!m_occ[i]) c++;
        return c;
    endfunction

    function automatic logic [N-1:0] m_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_occ[i];
        return v;
    endfunction

    task automatic do_entry(output bit got_alloc, output int slot, output bit got_deny,
                            output int a_edge, output int gate_n);
        entry_req = 1'b1;
        @(negedge clk);
        entry_req = 1'b0;
        got_alloc = alloc_valid;
        slot      = int'(alloc_slot);
        got_deny  = deny;
        a_edge    = edge_cnt;
        gate_n    = 0;
        for (int k = 0; k < 20 && entry_gate === 1'b1; k++) begin
            gate_n++;
            @(negedge clk);
        end
    endtask

    task automatic do_exit(input int slot, input int pay_delay, output bit err, output bit ready,
                           output logic [31:0] fee_v, output int b_edge, output int gate_n);
        exit_slot_sel = SW'(slot);
        exit_req = 1'b1;
        @(negedge clk);
        exit_req = 1'b0;
        err = exit_err;
        @(negedge clk);
        ready  = fee_ready;
        fee_v  = fee;
        b_edge = edge_cnt;
        gate_n = 0;
        if (!ready) return;
        repeat (pay_delay) @(negedge clk);
        payment_received = 1'b1;
        @(negedge clk);
        payment_received = 1'b0;
        for (int k = 0; k < 20 && exit_gate === 1'b1; k++) begin
            gate_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (occupancy !== '0 || full !== 1'b0) begin
            errors++; $display("FAIL reset_occ: occupancy=%h full=%b expected 00/0", occupancy, full);
        end
        checks++;
        if (free_count !== 4'(N)) begin
            errors++; $display("FAIL reset_free: got %0d expected %0d", free_count, N);
        end
        checks++;
        if ({entry_gate, exit_gate, alloc_valid, fee_ready, deny, exit_err, pay_timeout} !== 7'b0 || fee !== 32'd0) begin
            errors++; $display("FAIL reset_outputs: flags=%b fee=%0d expected 0/0",
                {entry_gate, exit_gate, alloc_valid, fee_ready, deny, exit_err, pay_timeout}, fee);
        end
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        bit ga, gd; int s, a, g;
        for (int i = 0; i < N; i++) begin
            do_entry(ga, s, gd, a, g);
            checks++;
            if (ga !== 1'b1 || gd !== 1'b0 || s != m_lowest() || g != GATE) begin
                errors++; $display("FAIL fill_alloc%0d: valid=%b deny=%b slot=%0d gate=%0d expected 1/0/%0d/%0d",
                    i, ga, gd, s, g, m_lowest(), GATE);
            end
            m_occ[m_lowest()] = 1'b1;
            m_alloc[s] = a;
        end
        checks++;
        if (full !== 1'b1 || free_count !== 4'd0 || occupancy !== m_vec()) begin
            errors++; $display("FAIL fill_full: full=%b free=%0d occ=%h expected 1/0/%h", full, free_count, occupancy, m_vec());
        end
        do_entry(ga, s, gd, a, g);
        checks++;
        if (gd !== 1'b1 || ga !== 1'b0 || g != 0) begin
            errors++; $display("FAIL fill_deny: deny=%b valid=%b gate=%0d expected 1/0/0", gd, ga, g);
        end
    endtask

    task automatic test_fee_seven_units();
        bit er, rd, ga, gd; logic [31:0] fv; int b, g, s, a;
        do_exit(3, 1, er, rd, fv, b, g);
        checks++;
        if (er !== 1'b0 || rd !== 1'b1 || fv !== exp_fee(m_alloc[3], b)) begin
            errors++; $display("FAIL first_exit: err=%b ready=%b fee=%0d expected 0/1/%0d", er, rd, fv, exp_fee(m_alloc[3], b));
        end
        m_occ[3] = 1'b0;
        do_entry(ga, s, gd, a, g);
        checks++;
        if (ga !== 1'b1 || s != 3) begin
            errors++; $display("FAIL realloc3: valid=%b slot=%0d expected 1/3", ga, s);
        end
        m_occ[3] = 1'b1;
        m_alloc[3] = a;
        for (int k = 0; k < 2000 && units(a, edge_cnt + 2) < 7; k++) @(negedge clk);
        do_exit(3, 2, er, rd, fv, b, g);
        checks++;
        if (rd !== 1'b1 || fv !== 32'd25 || fv !== exp_fee(a, b)) begin
            errors++; $display("FAIL fee_7units: ready=%b fee=%0d expected 1/25", rd, fv);
        end
        m_occ[3] = 1'b0;
        checks++;
        if (g != GATE || occupancy[3] !== 1'b0 || free_count !== 4'(m_free())) begin
            errors++; $display("FAIL exit_gate: gate=%0d occ3=%b free=%0d expected %0d/0/%0d", g, occupancy[3], free_count, GATE, m_free());
        end
    endtask

    task automatic test_short_and_err();
        bit er, rd, ga, gd; logic [31:0] fv; int b, g, s, a;
        do_entry(ga, s, gd, a, g);
        m_occ[3] = 1'b1;
        m_alloc[3] = a;
        for (int k = 0; k < 400 && units(a, edge_cnt + 2) < 1; k++) @(negedge clk);
        do_exit(3, 0, er, rd, fv, b, g);
        checks++;
        if (s != 3 || rd !== 1'b1 || fv !== 32'd0 || units(a, b) != 1) begin
            errors++; $display("FAIL fee_1unit: slot=%0d ready=%b fee=%0d expected 3/1/0", s, rd, fv);
        end
        m_occ[3] = 1'b0;
        do_exit(3, 0, er, rd, fv, b, g);
        checks++;
        if (er !== 1'b1 || rd !== 1'b0 || exit_gate !== 1'b0 || occupancy !== m_vec()) begin
            errors++; $display("FAIL exit_empty: err=%b ready=%b gate=%b occ=%h expected 1/0/0/%h", er, rd, exit_gate, occupancy, m_vec());
        end
    endtask

    task automatic test_simultaneous_timeout();
        int b, to;
        logic [31:0] ef;
        exit_slot_sel = '0;
        entry_req = 1'b1;
        exit_req  = 1'b1;
        @(negedge clk);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        checks++;
        if (alloc_valid !== 1'b0 || exit_err !== 1'b0 || deny !== 1'b0) begin
            errors++; $display("FAIL simult_pulses: valid=%b err=%b deny=%b expected 0/0/0", alloc_valid, exit_err, deny);
        end
        @(negedge clk);
        b  = edge_cnt;
        ef = exp_fee(m_alloc[0], b);
        checks++;
        if (fee_ready !== 1'b1 || fee !== ef) begin
            errors++; $display("FAIL simult_bill: ready=%b fee=%0d expected 1/%0d", fee_ready, fee, ef);
        end
        to = -1;
        for (int k = 0; k < PT + 100; k++) begin
            @(negedge clk);
            if (pay_timeout === 1'b1) begin
                to = edge_cnt;
                break;
            end
        end
        checks++;
        if (to != b + PT) begin
            errors++; $display("FAIL timeout_edge: got %0d expected %0d", to, b + PT);
        end
        checks++;
        if (occupancy[0] !== 1'b1 || fee_ready !== 1'b0 || fee !== ef || free_count !== 4'(m_free())) begin
            errors++; $display("FAIL timeout_state: occ0=%b ready=%b fee=%0d free=%0d expected 1/0/%0d/%0d",
                occupancy[0], fee_ready, fee, free_count, ef, m_free());
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        bit er, rd, ga, gd; logic [31:0] fv; int b, g, s, a, slot, exp_s;
        for (int it = 0; it < 16; it++) begin
            repeat ($urandom_range(0, 250)) @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
                exp_s = m_lowest();
                do_entry(ga, s, gd, a, g);
                checks++;
                if (exp_s < 0) begin
                    if (gd !== 1'b1 || ga !== 1'b0) begin
                        errors++; $display("FAIL rand_deny%0d: deny=%b valid=%b expected 1/0", it, gd, ga);
                    end
                end else begin
                    if (ga !== 1'b1 || s != exp_s || g != GATE) begin
                        errors++; $display("FAIL rand_alloc%0d: valid=%b slot=%0d gate=%0d expected 1/%0d/%0d", it, ga, s, g, exp_s, GATE);
                    end
                    m_occ[exp_s] = 1'b1;
                    m_alloc[exp_s] = a;
                end
            end else begin
                slot = $urandom_range(0, N - 1);
                do_exit(slot, $urandom_range(0, 20), er, rd, fv, b, g);
                checks++;
                if (m_occ[slot]) begin
                    if (er !== 1'b0 || rd !== 1'b1 || fv !== exp_fee(m_alloc[slot], b) || g != GATE) begin
                        errors++; $display("FAIL rand_exit%0d: slot=%0d err=%b ready=%b fee=%0d gate=%0d expected 0/1/%0d/%0d",
                            it, slot, er, rd, fv, g, exp_fee(m_alloc[slot], b), GATE);
                    end
                    m_occ[slot] = 1'b0;
                end else if (er !== 1'b1 || rd !== 1'b0) begin
                    errors++; $display("FAIL rand_err%0d: slot=%0d err=%b ready=%b expected 1/0", it, slot, er, rd);
                end
            end
            checks++;
            if (occupancy !== m_vec() || free_count !== 4'(m_free()) || full !== (m_free() == 0)) begin
                errors++; $display("FAIL rand_occ%0d: occ=%h free=%0d full=%b expected %h/%0d/%b",
                    it, occupancy, free_count, full, m_vec(), m_free(), m_free() == 0);
            end
        end
    endtask

    task automatic test_reset_midpay();
        bit ga, gd; int s, a, g, slot;
        slot = -1;
        for (int i = N - 1; i >= 0; i--) if (m_occ[i]) slot = i;
        if (slot < 0) begin
            do_entry(ga, s, gd, a, g);
            slot = s;
        end
        exit_slot_sel = SW'(slot);
        exit_req = 1'b1;
        @(negedge clk);
        exit_req = 1'b0;
        @(negedge clk);
        checks++;
        if (fee_ready !== 1'b1) begin
            errors++; $display("FAIL midpay_ready: got %b expected 1", fee_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fee_ready !== 1'b0 || occupancy !== '0 || free_count !== 4'(N) || full !== 1'b0 || fee !== 32'd0 ||
            exit_gate !== 1'b0 || entry_gate !== 1'b0 || pay_timeout !== 1'b0) begin
            errors++; $display("FAIL midpay_reset: ready=%b occ=%h free=%0d full=%b fee=%0d expected 0/00/%0d/0/0",
                fee_ready, occupancy, free_count, full, fee, N);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
        @(negedge clk);
        do_entry(ga, s, gd, a, g);
        checks++;
        if (ga !== 1'b1 || s != 0 || free_count !== 4'(N - 1)) begin
            errors++; $display("FAIL post_reset_alloc: valid=%b slot=%0d free=%0d expected 1/0/%0d", ga, s, free_count, N - 1);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_fee_seven_units();
        test_short_and_err();
        test_simultaneous_timeout();
        test_random();
        test_reset_midpay();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
